// File: rtl/xs3_serial_decoder_if.sv
// rtl/xs3_serial_decoder_if.sv - serial Excess-3 input and decoded BCD output bundle
interface xs3_serial_decoder_if #(
  parameter int DIGITS = 2
);
  logic                  sin;
  logic                  sin_valid;
  logic                  sof;
  logic                  a;
  logic                  b;
  logic                  c;
  logic                  d;
  logic                  dig_valid;
  logic                  err;
  logic [4*DIGITS-1:0]   word;
  logic                  word_valid;
  logic                  word_err;

  modport master (
    output sin, sin_valid, sof,
    input  a, b, c, d, dig_valid, err, word, word_valid, word_err
  );

  modport slave (
    input  sin, sin_valid, sof,
    output a, b, c, d, dig_valid, err, word, word_valid, word_err
  );
endinterface

// File: rtl/xs3_serial_decoder.sv
// rtl/xs3_serial_decoder.sv - bit-serial Excess-3 to BCD decoder with DIGITS-wide word packing
module xs3_serial_decoder #(
  parameter int DIGITS = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  xs3_serial_decoder_if.slave bus
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {
    IDLE,
    RECV
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           bit_cnt_q, bit_cnt_d;
  logic [2:0]           shreg_q, shreg_d;
  logic [IDX_W-1:0]     dig_idx_q, dig_idx_d;
  logic [3:0]           digit_q, digit_d;
  logic                 err_q, err_d;
  logic                 dig_valid_q, dig_valid_d;
  logic [4*DIGITS-1:0]  word_q, word_d;
  logic                 word_valid_q, word_valid_d;
  logic                 word_err_q, word_err_d;

  logic [3:0]           code;
  logic                 code_ok;
  logic [3:0]           dec;
  logic                 accept_sof;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bit_cnt_q    <= 2'd0;
      shreg_q      <= 3'd0;
      dig_idx_q    <= '0;
      digit_q      <= 4'd0;
      err_q        <= 1'b0;
      dig_valid_q  <= 1'b0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      word_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      dig_idx_q    <= dig_idx_d;
      digit_q      <= digit_d;
      err_q        <= err_d;
      dig_valid_q  <= dig_valid_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      word_err_q   <= word_err_d;
    end
  end

  // shreg_q holds {w,x,y} by the time z arrives, so the full code is available combinationally
  assign code       = {shreg_q, bus.sin};
  assign code_ok    = (code >= 4'd3) && (code <= 4'd12);
  assign dec        = code_ok ? (code - 4'd3) : 4'hF;
  assign accept_sof = bus.sin_valid && bus.sof;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    dig_idx_d    = dig_idx_q;
    digit_d      = digit_q;
    err_d        = err_q;
    dig_valid_d  = 1'b0;
    word_d       = word_q;
    word_valid_d = 1'b0;
    word_err_d   = word_err_q;

    if (accept_sof) begin
      // sof restarts the frame from either state, dropping any partial digit/word
      state_d   = RECV;
      shreg_d   = {2'b00, bus.sin};
      bit_cnt_d = 2'd1;
      dig_idx_d = '0;
    end else if (state_q == RECV && bus.sin_valid) begin
      shreg_d   = {shreg_q[1:0], bus.sin};
      bit_cnt_d = bit_cnt_q + 2'd1;
      if (bit_cnt_q == 2'd3) begin
        digit_d     = dec;
        err_d       = !code_ok;
        dig_valid_d = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
          if (i == DIGITS - 1 - int'(dig_idx_q)) begin
            word_d[4*i +: 4] = dec;
          end
        end
        // first digit of a frame restarts the error accumulation
        word_err_d = !code_ok || ((dig_idx_q != '0) && word_err_q);
        if (dig_idx_q == IDX_W'(DIGITS - 1)) begin
          word_valid_d = 1'b1;
          dig_idx_d    = '0;
          state_d      = IDLE;
        end else begin
          dig_idx_d = dig_idx_q + IDX_W'(1);
        end
      end
    end
  end

  assign bus.a          = digit_q[3];
  assign bus.b          = digit_q[2];
  assign bus.c          = digit_q[1];
  assign bus.d          = digit_q[0];
  assign bus.err        = err_q;
  assign bus.dig_valid  = dig_valid_q;
  assign bus.word       = word_q;
  assign bus.word_valid = word_valid_q;
  assign bus.word_err   = word_err_q;

endmodule

// File: tb/tb_xs3_serial_decoder.sv
// tb/tb_xs3_serial_decoder.sv - directed self-checking bench for xs3_serial_decoder
module tb_xs3_serial_decoder;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  logic [4:0] dig_log[$];
  int         n_word;
  logic [7:0] last_word;
  logic       last_werr;
  logic       last_wv_dv;
  int         bd;
  int         bw;

  xs3_serial_decoder_if #(.DIGITS(2)) bus ();

  xs3_serial_decoder #(.DIGITS(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.dig_valid) dig_log.push_back({bus.err, bus.a, bus.b, bus.c, bus.d});
    if (bus.word_valid) begin
      n_word     = n_word + 1;
      last_word  = bus.word;
      last_werr  = bus.word_err;
      last_wv_dv = bus.dig_valid;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic sv, input logic sf, input logic bt);
    @(negedge clk);
    #1;
    bus.sin_valid = sv;
    bus.sof       = sf;
    bus.sin       = bt;
  endtask

  task automatic send_code(input logic sf, input logic [3:0] code);
    drive(1'b1, sf, code[3]);
    drive(1'b1, 1'b0, code[2]);
    drive(1'b1, 1'b0, code[1]);
    drive(1'b1, 1'b0, code[0]);
  endtask

  task automatic settle();
    repeat (3) drive(1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] all_outs();
    return {bus.a, bus.b, bus.c, bus.d, bus.err, bus.dig_valid, bus.word, bus.word_valid, bus.word_err};
  endfunction

  initial begin
    tests = 0;
    fails = 0;
    n_word = 0;
    last_word = 8'h00;
    last_werr = 1'b0;
    last_wv_dv = 1'b0;
    bus.sin = 1'b0;
    bus.sin_valid = 1'b0;
    bus.sof = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", all_outs(), 32'h0);
    rst_n = 1'b1;

    // bits without sof in IDLE are ignored
    send_code(1'b0, 4'b0111);
    send_code(1'b0, 4'b0111);
    settle();
    check("nosof_dig_cnt", dig_log.size(), 0);
    check("nosof_word_cnt", n_word, 0);
    check("nosof_outputs", all_outs(), 32'h0);

    // contiguous two-digit frame 0111 1100 -> 4, 9
    bd = dig_log.size();
    bw = n_word;
    send_code(1'b1, 4'b0111);
    send_code(1'b0, 4'b1100);
    settle();
    check("t1_dig_cnt", dig_log.size() - bd, 2);
    check("t1_dig0", dig_log[bd], 5'b00100);
    check("t1_dig1", dig_log[bd+1], 5'b01001);
    check("t1_word_cnt", n_word - bw, 1);
    check("t1_word", last_word, 8'h49);
    check("t1_word_err", last_werr, 1'b0);
    check("t1_wv_with_dv", last_wv_dv, 1'b1);

    // back in IDLE: a code without sof produces nothing
    bd = dig_log.size();
    send_code(1'b0, 4'b0011);
    settle();
    check("t1_idle_after_word", dig_log.size() - bd, 0);

    // gapped single digit, code 1000 -> 0101
    bd = dig_log.size();
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    check("t2_no_early_dv", dig_log.size() - bd, 0);
    drive(1'b1, 1'b0, 1'b0);
    check("t2_no_dv_before_4th_sampled", bus.dig_valid, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    check("t2_dv_latency", bus.dig_valid, 1'b1);
    check("t2_digit", {bus.err, bus.a, bus.b, bus.c, bus.d}, 5'b00101);
    drive(1'b0, 1'b0, 1'b0);
    check("t2_dv_one_cycle", bus.dig_valid, 1'b0);
    check("t2_digit_held", {bus.a, bus.b, bus.c, bus.d}, 4'b0101);

    // invalid code then valid 0011 (sof aborts the pending frame from t2)
    bd = dig_log.size();
    bw = n_word;
    send_code(1'b1, 4'b0001);
    send_code(1'b0, 4'b0011);
    settle();
    check("t3_dig0", dig_log[bd], 5'b11111);
    check("t3_dig1", dig_log[bd+1], 5'b00000);
    check("t3_word_cnt", n_word - bw, 1);
    check("t3_word", last_word, 8'hF0);
    check("t3_word_err", last_werr, 1'b1);

    // aborted partial digit then 1100, 0011 -> 9, 0
    bd = dig_log.size();
    bw = n_word;
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    send_code(1'b1, 4'b1100);
    send_code(1'b0, 4'b0011);
    settle();
    check("t5_dig_cnt", dig_log.size() - bd, 2);
    check("t5_dig0", dig_log[bd], 5'b01001);
    check("t5_word_cnt", n_word - bw, 1);
    check("t5_word", last_word, 8'h90);
    check("t5_word_err", last_werr, 1'b0);

    // reset mid-frame, then a fresh frame 0100 0101 -> 1, 2
    bd = dig_log.size();
    bw = n_word;
    send_code(1'b1, 4'b0100);
    drive(1'b0, 1'b0, 1'b0);
    check("t6_first_digit", dig_log.size() - bd, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_reset_outputs", all_outs(), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bd = dig_log.size();
    bw = n_word;
    send_code(1'b1, 4'b0100);
    send_code(1'b0, 4'b0101);
    settle();
    check("t6_dig_cnt", dig_log.size() - bd, 2);
    check("t6_dig1", dig_log[bd+1], 5'b00010);
    check("t6_word_cnt", n_word - bw, 1);
    check("t6_word", last_word, 8'h12);
    check("t6_word_err", last_werr, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/xs3_serial_decoder.md
Name: xs3_serial_decoder

Overview:
- Receiving end of the lab 2 Excess-3 code path. It takes Excess-3 digits as a bit-serial stream, MSB first (w, x, y, z order).
- Each 4-bit code is converted back to a BCD digit on a, b, c, d.
- Codes outside 3..12 are flagged as invalid.
- Consecutive digits are packed into a DIGITS-wide BCD word with a completion strobe, for use by display and checker logic downstream.

Parameters:
- DIGITS, 2, number of BCD digits per frame/word (1..8).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- sin  input  1  serial Excess-3 data bit
- sin_valid  input  1  sin is sampled on this edge
- sof  input  1  start of frame; qualified by sin_valid; marks sin as bit w of the first digit
- a  output  1  decoded BCD bit 3 (MSB)
- b  output  1  decoded BCD bit 2
- c  output  1  decoded BCD bit 1
- d  output  1  decoded BCD bit 0
- dig_valid  output  1  one-cycle pulse: a..d hold a new digit
- err  output  1  the digit in a..d came from an invalid code; held with a..d
- word  output  4*DIGITS  packed BCD word; the first-received digit sits in the most significant nibble
- word_valid  output  1  one-cycle pulse: word is complete
- word_err  output  1  OR of err over the digits of word; held with word

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; bit count=0; digit index=0; shift register=0.
  - a=b=c=d=0, dig_valid=0, err=0, word=0, word_valid=0, word_err=0.
- State IDLE:
  - A bit is accepted only when sin_valid=1 and sof=1. That bit is loaded as w, bit count becomes 1, and the block moves to RECV.
  - sin_valid=1 with sof=0 is ignored.
- State RECV:
  - Each edge with sin_valid=1 shifts sin in and increments the bit count.
  - sin_valid=0 holds all state. Gaps of any length are allowed.
- Digit completion:
  - On the edge that samples the 4th bit, the code {w,x,y,z} is decoded and registered.
  - Valid codes 0011..1100: a..d = code-3 (4-bit subtract, no carry out), err=0.
  - Invalid codes 0000, 0001, 0010, 1101, 1110, 1111: a..d=1111, err=1.
  - dig_valid=1 for the following cycle only. Latency is one clock from the 4th bit sample to visible outputs.
  - a..d and err hold until the next digit completes.
  - The digit is written into the nibble selected by the digit index, and the index increments.
- Word completion:
  - When the DIGITS-th digit completes, word_valid pulses in the same cycle as that digit's dig_valid.
  - word_err = OR of that word's err values.
  - The digit index clears and state returns to IDLE; the next word requires a new sof.
- Word register update:
  - Nibbles of word update as digits arrive.
  - word_err accumulates and is cleared at the first digit of a new frame.
- sof during RECV (with sin_valid):
  - Any partial digit and partial word are discarded.
  - sin is loaded as w of digit 0, bit count=1, and word_err accumulation is cleared.
  - No dig_valid or word_valid is produced for the aborted data.
- sof without sin_valid is ignored in all states.
- Reset asserted mid-frame: immediate return to the reset values; no pulses are emitted for partial data.
- Mid-frame wrap-around: the bit count wraps 3→0 after each digit, so the next valid bit starts the next digit without a new sof.

Test Plan:
- DIGITS=2; sof with bit 0; then bits 1,1,1,1,1,0,0 contiguous → first dig_valid with a..d=0100, err=0; second dig_valid with a..d=1001 and word_valid in the same cycle; word=8'h49, word_err=0; state back to IDLE.
- Single-digit input with sin_valid toggling 1,0,0,1,0,1,1 carrying bits 1,0,0,0 (code 1000) → no dig_valid until the 4th accepted bit; then a..d=0101.
- Code 0001 followed by code 0011 → first digit a..d=1111 with err=1; second digit a..d=0000 with err=0; word=8'hF0, word_err=1.
- Bits with sin_valid=1 and sof=0 while in IDLE (0111 repeated twice) → no dig_valid and no word_valid; outputs stay at reset values.
- sof, then 2 bits, then sof again followed by codes 1100 and 0011 → exactly two dig_valid pulses; word=8'h90; no pulse for the aborted digit.
- rst_n=0 for one cycle after the first digit of a frame → all outputs return to 0 immediately; a new frame 0100,0101 decodes to word=8'h12 with a single word_valid.
